// File: rtl/uart_io_sequencer.sv
// uart_io_sequencer
// Sequences IN/OUT instructions between the write-back stage and the UART
// byte streams. IN gathers WORD_BYTES received bytes (little-endian) and
// issues a single register-file write. OUT sends WORD_BYTES bytes of a
// latched source word. The pipeline is held for the whole transfer.

module uart_io_sequencer #(
    parameter int WORD_BYTES = 1,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_req,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  out_req,
    input  logic [31:0]           out_data,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic                  stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [31:0]           rf_wdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        TX   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Index of the final byte of a word; cnt never exceeds it.
    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    state_t                state_reg, state_next;
    logic [1:0]            cnt_reg, cnt_next;
    logic [31:0]           data_reg, data_next;
    logic [REG_ADDR_W-1:0] addr_reg, addr_next;
    logic                  is_in_reg, is_in_next;

    // Bit offset of the byte lane addressed by the current count.
    logic [4:0] lane_sel;
    assign lane_sel = {cnt_reg, 3'b000};

    // The write port always reflects the latched address and word; the
    // strobe alone decides whether a write happens.
    assign rf_waddr = addr_reg;
    assign rf_wdata = data_reg;

    // State, byte counter and latched instruction operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            data_reg  <= 32'd0;
            addr_reg  <= '0;
            is_in_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            addr_reg  <= addr_next;
            is_in_reg <= is_in_next;
        end
    end

    // Next-state sequencing and handshake/stall outputs.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        addr_next  = addr_reg;
        is_in_next = is_in_reg;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        stall      = 1'b0;
        rf_we      = 1'b0;

        case (state_reg)
            IDLE: begin
                // Freeze the pipeline in the very cycle the request shows up.
                stall = in_req | out_req;
                if (in_req) begin
                    // IN has priority; a simultaneous OUT is not a legal case.
                    addr_next  = in_rd;
                    data_next  = 32'd0;
                    cnt_next   = 2'd0;
                    is_in_next = 1'b1;
                    state_next = RX;
                end else if (out_req) begin
                    data_next  = out_data;
                    cnt_next   = 2'd0;
                    is_in_next = 1'b0;
                    state_next = TX;
                end
            end

            RX: begin
                rx_ready = 1'b1;
                stall    = 1'b1;
                if (rx_valid) begin
                    data_next[lane_sel +: 8] = rx_data;
                    if (cnt_reg == LAST_BYTE) begin
                        cnt_next   = 2'd0;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + 2'd1;
                    end
                end
            end

            TX: begin
                // Byte comes from the latched word, so it stays stable even if
                // out_data changes while the transmitter is back-pressuring.
                tx_valid = 1'b1;
                tx_data  = data_reg[lane_sel +: 8];
                stall    = 1'b1;
                if (tx_ready) begin
                    if (cnt_reg == LAST_BYTE) begin
                        cnt_next   = 2'd0;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + 2'd1;
                    end
                end
            end

            DONE: begin
                // Pipeline released; the completing instruction retires now.
                rf_we      = is_in_reg;
                cnt_next   = 2'd0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
